decode_issue_stage: RTL and testbench
=====================================

Name: decode_issue_stage

Overview:
Registered decode/issue stage between the IF/ID latch and EX. Resolves rs1/rs2 operands through a parametrised, priority-ordered forwarding network over NUM_FWD producer stages. Detects load-use hazards from producers whose data is not yet available, and stalls upstream. Holds the decoded operands in an ID/EX output register behind a valid/ready handshake, with flush support and an optional saturating stall counter.

Parameters:
XLEN, 64, register/data width
NUM_FWD, 3, number of forwarding sources; index 0 = youngest = highest priority
NREGS, 32, architectural register count (address width = $clog2(NREGS))
INST_W, 32, instruction width
CNT_W, 32, stall counter width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
in_valid  input  1  IF/ID entry valid
in_ready  output  1  stage accepts entry this cycle
in_inst  input  INST_W  instruction
in_pc  input  XLEN  instruction PC
in_counter  input  64  instruction sequence counter
fwd_valid  input  NUM_FWD  producer writes a register
fwd_addr  input  NUM_FWD*5  producer destination address
fwd_data  input  NUM_FWD*XLEN  producer result
fwd_pending  input  NUM_FWD  producer result not yet available (load in EX)
regs_value  input  NREGS*XLEN  architectural register file contents
flush  input  1  kill in-flight/incoming entry (branch/trap redirect)
out_valid  output  1  ID/EX entry valid
out_ready  input  1  EX consumes entry
out_inst, out_pc, out_counter  output  INST_W/XLEN/64  registered copies
out_rs1_addr, out_rs2_addr  output  5 each  inst[19:15], inst[24:20]
out_rs1_val, out_rs2_val  output  XLEN each  resolved operands
stall_cycles  output  CNT_W  load-use stall cycle count

Behaviour:
- Reset (reset==0 at posedge): every output register cleared to 0; out_valid=0; stall_cycles=0. in_ready is combinational and reads 0 while reset is low.
- Operand use (from opcode inst[6:0]):
  - rs1 is used except for LUI 0110111, AUIPC 0010111, JAL 1101111.
  - rs2 is used only for 0110011, 0111011, 0100011, 1100011.
- Forward match for source i: fwd_valid[i] && fwd_addr[i]!=0 && fwd_addr[i]==rsX. The lowest matching index wins. No match selects regs_value[rsX]. Register x0 always reads 0.
- Hazard: a used rsX whose winning source has fwd_pending=1. A pending source shadowed by a lower-index non-pending match is not a hazard.
- Handshake:
  - in_ready = reset && !flush && !hazard && (!out_valid || out_ready).
  - accept = in_valid && in_ready.
  - On accept: output regs load next cycle and out_valid<=1.
  - If no accept and out_valid && out_ready: out_valid<=0.
  - While out_valid && !out_ready, all out_* stay stable.
- Latency: one cycle from accept to out_valid. Full throughput (one entry per cycle) when there is no hazard and out_ready=1.
- Flush: out_valid<=0 next cycle. No accept occurs that cycle. Flush takes priority over both accept and hold. Payload registers may keep stale values.
- Operands are sampled only at accept. Forwarding changes while the entry is held in the output register do not update it.
- Reset mid-stall or mid-hold: the entry is dropped and the counter is cleared.

Optional Feature:
DECODE_STALL_CNT_EN
- Defined: stall_cycles increments by 1 on each cycle with reset && in_valid && hazard && !flush. It saturates at all-ones and does not wrap.
- Undefined: no counter logic; stall_cycles is tied to 0. The port list is unchanged.

Test Plan:
- Forward priority: rs1=5, fwd_valid=3'b110, fwd_addr[1]=5 data 0xAA, fwd_addr[2]=5 data 0xBB, regs[5]=0x11 -> out_rs1_val=0xAA one cycle after accept. With fwd_valid=0 -> 0x11.
- x0 guard: ADD x1,x0,x2 with fwd_addr[0]=0 data 0xFF, fwd_valid[0]=1 -> out_rs1_val=0, no hazard.
- Load-use: ADD rs2=7 with fwd_pending[0]=1, fwd_addr[0]=7 for 2 cycles -> in_ready=0 for 2 cycles, stall_cycles=2 (macro on) or 0 (off). Issue on cycle 3 with forwarded value.
- Unused operand: LUI with rd/rs1 field bits equal to a pending load address -> no stall, accepted immediately.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_* stable and in_ready=0. out_ready=1 -> the next entry loads in the same cycle.
- Flush: flush=1 while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, the input is not accepted. Reset low mid-hold -> out_valid=0, stall_cycles=0.

Source files
------------

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: resolves rs1/rs2 through a priority forwarding network, stalls on load-use
// hazards and holds the decoded entry in a valid/ready ID/EX register. Define DECODE_STALL_CNT_EN for the stall counter.
module decode_issue_stage #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned INST_W  = 32,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INST_W-1:0]         in_inst,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [63:0]               in_counter,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*5-1:0]      fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  input  logic [NREGS*XLEN-1:0]     regs_value,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INST_W-1:0]         out_inst,
  output logic [XLEN-1:0]           out_pc,
  output logic [63:0]               out_counter,
  output logic [4:0]                out_rs1_addr,
  output logic [4:0]                out_rs2_addr,
  output logic [XLEN-1:0]           out_rs1_val,
  output logic [XLEN-1:0]           out_rs2_val,
  output logic [CNT_W-1:0]          stall_cycles
);

  localparam int unsigned RAW = 5;
  localparam int unsigned AW  = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [6:0]      opcode;
  logic            rs1_used;
  logic            rs2_used;
  logic            hazard;
  logic            accept;

  logic [RAW-1:0]  rs_addr [2];
  logic [XLEN-1:0] rs_val  [2];
  logic            rs_pend [2];
  logic            rs_hit  [2];

  logic [XLEN-1:0] reg_file [NREGS];
  logic [RAW-1:0]  src_addr [NUM_FWD];
  logic [XLEN-1:0] src_data [NUM_FWD];

  // Flat bus slices viewed as arrays
  for (genvar g = 0; g < NREGS; g++) begin : g_regs
    assign reg_file[g] = regs_value[g*XLEN +: XLEN];
  end

  for (genvar g = 0; g < NUM_FWD; g++) begin : g_src
    assign src_addr[g] = fwd_addr[g*RAW +: RAW];
    assign src_data[g] = fwd_data[g*XLEN +: XLEN];
  end

  assign opcode     = in_inst[6:0];
  assign rs_addr[0] = in_inst[19:15];
  assign rs_addr[1] = in_inst[24:20];

  always_comb begin
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    if (opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL) begin
      rs1_used = 1'b0;
    end
    if (opcode == OP_REG || opcode == OP_REG32 || opcode == OP_STORE || opcode == OP_BRANCH) begin
      rs2_used = 1'b1;
    end
  end

  // Operand resolution: first (lowest-index) matching producer wins, else register file; x0 reads zero
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rs_hit[k]  = 1'b0;
      rs_pend[k] = 1'b0;
      rs_val[k]  = '0;
      if (rs_addr[k] != '0 && 32'(rs_addr[k]) < NREGS) begin
        rs_val[k] = reg_file[AW'(rs_addr[k])];
      end
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!rs_hit[k] && fwd_valid[i] && src_addr[i] != '0 && src_addr[i] == rs_addr[k]) begin
          rs_hit[k]  = 1'b1;
          rs_val[k]  = src_data[i];
          rs_pend[k] = fwd_pending[i];
        end
      end
    end
  end

  // A shadowed pending producer never causes a stall since only the winner's pending bit is kept
  assign hazard   = (rs1_used && rs_pend[0]) || (rs2_used && rs_pend[1]);
  assign in_ready = reset && !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // ID/EX register; flush overrides accept and hold, payload may stay stale
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_inst     <= '0;
      out_pc       <= '0;
      out_counter  <= '0;
      out_rs1_addr <= '0;
      out_rs2_addr <= '0;
      out_rs1_val  <= '0;
      out_rs2_val  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_inst     <= in_inst;
      out_pc       <= in_pc;
      out_counter  <= in_counter;
      out_rs1_addr <= rs_addr[0];
      out_rs2_addr <= rs_addr[1];
      out_rs1_val  <= rs_val[0];
      out_rs2_val  <= rs_val[1];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECODE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  // Saturating count of cycles an incoming entry is held back by a load-use hazard
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (in_valid && hazard && !flush && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_decode_issue_stage.sv
// Randomized bench for decode_issue_stage with an in-bench behavioural model and directed literal checks.
module tb_decode_issue_stage;
  localparam int unsigned XLEN    = 64;
  localparam int unsigned NUM_FWD = 3;
  localparam int unsigned NREGS   = 32;
  localparam int unsigned INST_W  = 32;
  localparam int unsigned CNT_W   = 32;
`ifdef DECODE_STALL_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [INST_W-1:0] in_inst, out_inst;
  logic [XLEN-1:0] in_pc, out_pc, out_rs1_val, out_rs2_val;
  logic [63:0] in_counter, out_counter;
  logic [NUM_FWD-1:0] fwd_valid, fwd_pending;
  logic [NUM_FWD*5-1:0] fwd_addr;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic [NREGS*XLEN-1:0] regs_value;
  logic [4:0] out_rs1_addr, out_rs2_addr;
  logic [CNT_W-1:0] stall_cycles;

  logic            f_valid [NUM_FWD];
  logic [4:0]      f_addr  [NUM_FWD];
  logic [XLEN-1:0] f_data  [NUM_FWD];
  logic            f_pend  [NUM_FWD];
  logic [XLEN-1:0] regs    [NREGS];

  logic            m_valid = 1'b0;
  logic            m_pay_known = 1'b0;
  logic [31:0]     m_inst = '0;
  logic [63:0]     m_pc = '0, m_ctr = '0, m_v1 = '0, m_v2 = '0;
  logic [CNT_W-1:0] m_stall = '0;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  decode_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_counter(in_counter),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_pending(fwd_pending),
    .regs_value(regs_value), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_counter(out_counter),
    .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .stall_cycles(stall_cycles)
  );

  always_comb begin
    for (int i = 0; i < NUM_FWD; i++) begin
      fwd_valid[i]             = f_valid[i];
      fwd_pending[i]           = f_pend[i];
      fwd_addr[i*5 +: 5]       = f_addr[i];
      fwd_data[i*XLEN +: XLEN] = f_data[i];
    end
    for (int r = 0; r < NREGS; r++) regs_value[r*XLEN +: XLEN] = regs[r];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Winner is the lowest matching index: scan from the top and let lower hits overwrite
  function automatic void resolve(input logic [4:0] rs, output logic [XLEN-1:0] v, output logic pend);
    v = (rs == 5'd0) ? '0 : regs[rs];
    pend = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (f_valid[i] && f_addr[i] != 5'd0 && f_addr[i] == rs) begin
        v = f_data[i];
        pend = f_pend[i];
      end
    end
  endfunction

  function automatic logic m_hazard();
    logic [6:0] op;
    logic u1, u2, p1, p2;
    logic [XLEN-1:0] v;
    op = in_inst[6:0];
    u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    u2 = (op == 7'h33 || op == 7'h3B || op == 7'h23 || op == 7'h63);
    resolve(in_inst[19:15], v, p1);
    resolve(in_inst[24:20], v, p2);
    return (u1 && p1) || (u2 && p2);
  endfunction

  function automatic logic m_ready();
    return reset && !flush && !m_hazard() && (!m_valid || out_ready);
  endfunction

  // Reference model state update
  always @(posedge clk) begin
    logic h, acc, p;
    if (!reset) begin
      m_valid = 1'b0; m_pay_known = 1'b1; m_inst = '0; m_pc = '0; m_ctr = '0;
      m_v1 = '0; m_v2 = '0; m_stall = '0;
    end else begin
      h = m_hazard();
      acc = in_valid && m_ready();
      if (CNT_ON != 0 && in_valid && h && !flush && m_stall != '1) m_stall = m_stall + 1;
      if (flush) begin
        m_valid = 1'b0; m_pay_known = 1'b0;
      end else if (acc) begin
        m_valid = 1'b1; m_pay_known = 1'b1;
        m_inst = in_inst; m_pc = in_pc; m_ctr = in_counter;
        resolve(in_inst[19:15], m_v1, p);
        resolve(in_inst[24:20], m_v2, p);
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare process, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
      chk("in_ready", 64'(in_ready), 64'(m_ready()));
      if (m_pay_known) begin
        chk("out_inst", 64'(out_inst), 64'(m_inst));
        chk("out_pc", out_pc, m_pc);
        chk("out_counter", out_counter, m_ctr);
        chk("out_rs1_addr", 64'(out_rs1_addr), 64'(m_inst[19:15]));
        chk("out_rs2_addr", 64'(out_rs2_addr), 64'(m_inst[24:20]));
        chk("out_rs1_val", out_rs1_val, m_v1);
        chk("out_rs2_val", out_rs2_val, m_v2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < NUM_FWD; i++) begin
      f_valid[i] = 1'b0; f_pend[i] = 1'b0; f_addr[i] = 5'd0; f_data[i] = '0;
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
  endfunction

  initial begin
    logic [31:0] lui_inst, bp_inst;
    logic [6:0] ops [10];
    ops = '{7'h33, 7'h3B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h13, 7'h03, 7'h67};
    reset = 1'b0;
    idle();
    in_inst = '0; in_pc = '0; in_counter = '0;
    for (int r = 0; r < NREGS; r++) regs[r] = {$urandom, $urandom};
    regs[5] = 64'h11;
    regs[2] = 64'h22;

    tick();
    chk_en = 1'b1;
    tick();
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stall", 64'(stall_cycles), 64'd0);
    reset = 1'b1;

    // Forward priority, then plain register file read
    in_inst = mk_r(5'd3, 5'd5, 5'd0); in_pc = 64'h1000; in_counter = 64'd1; in_valid = 1'b1;
    f_valid[1] = 1'b1; f_addr[1] = 5'd5; f_data[1] = 64'hAA;
    f_valid[2] = 1'b1; f_addr[2] = 5'd5; f_data[2] = 64'hBB;
    tick();
    in_valid = 1'b0;
    chk("fwd_prio_valid", 64'(out_valid), 64'd1);
    chk("fwd_prio", out_rs1_val, 64'hAA);
    f_valid[1] = 1'b0; f_valid[2] = 1'b0; in_counter = 64'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("regfile_read", out_rs1_val, 64'h11);

    // x0 guard
    idle();
    f_valid[0] = 1'b1; f_addr[0] = 5'd0; f_data[0] = 64'hFF;
    in_inst = mk_r(5'd1, 5'd0, 5'd2); in_valid = 1'b1;
    #1 chk("x0_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("x0_rs1", out_rs1_val, 64'd0);
    chk("x0_rs2", out_rs2_val, 64'h22);

    // Load-use stall for two cycles
    idle();
    f_valid[0] = 1'b1; f_addr[0] = 5'd7; f_pend[0] = 1'b1; f_data[0] = 64'h77;
    in_inst = mk_r(5'd4, 5'd1, 5'd7); in_valid = 1'b1;
    repeat (2) begin
      #1 chk("lu_stall_ready", 64'(in_ready), 64'd0);
      tick();
    end
    chk("lu_stall_cnt", 64'(stall_cycles), 64'(2 * CNT_ON));
    chk("lu_no_issue", 64'(out_valid), 64'd0);
    f_pend[0] = 1'b0;
    #1 chk("lu_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("lu_issue", 64'(out_valid), 64'd1);
    chk("lu_fwd", out_rs2_val, 64'h77);

    // LUI with operand fields aliasing a pending load
    idle();
    f_valid[0] = 1'b1; f_addr[0] = 5'd7; f_pend[0] = 1'b1;
    lui_inst = {7'd0, 5'd7, 5'd7, 3'd0, 5'd7, 7'b0110111};
    in_inst = lui_inst; in_valid = 1'b1;
    #1 chk("lui_ready", 64'(in_ready), 64'd1);
    tick();
    chk("lui_inst", 64'(out_inst), 64'(lui_inst));

    // Backpressure hold then same-cycle reload
    f_pend[0] = 1'b0; f_valid[0] = 1'b0;
    bp_inst = mk_r(5'd8, 5'd3, 5'd4);
    in_inst = bp_inst; in_counter = 64'd9; out_ready = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      #1 chk("bp_ready", 64'(in_ready), 64'd0);
      tick();
      chk("bp_hold", 64'(out_inst), 64'(lui_inst));
      chk("bp_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    chk("bp_load", 64'(out_inst), 64'(bp_inst));
    chk("bp_counter", out_counter, 64'd9);

    // Flush beats incoming entry
    in_inst = mk_r(5'd9, 5'd1, 5'd1); in_counter = 64'd10; flush = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
    #1 chk("fl_ready", 64'(in_ready), 64'd0);
    tick();
    chk("fl_valid", 64'(out_valid), 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("fl_no_accept", 64'(out_valid), 64'd0);

    // Reset in the middle of a hold and a stall
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    chk("hold_valid", 64'(out_valid), 64'd1);
    f_valid[0] = 1'b1; f_addr[0] = 5'd7; f_pend[0] = 1'b1;
    in_inst = mk_r(5'd4, 5'd1, 5'd7);
    tick();
    chk("hold_cnt", 64'(stall_cycles), 64'(3 * CNT_ON));
    reset = 1'b0;
    tick();
    chk("rst_hold_valid", 64'(out_valid), 64'd0);
    chk("rst_hold_cnt", 64'(stall_cycles), 64'd0);
    reset = 1'b1;
    idle();

    // Randomized traffic
    repeat (3000) begin
      reset     = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_inst   = $urandom;
      in_inst[6:0]   = ops[$urandom_range(0, 9)];
      in_inst[19:15] = 5'($urandom_range(0, 7));
      in_inst[24:20] = 5'($urandom_range(0, 7));
      in_pc      = {$urandom, $urandom};
      in_counter = {$urandom, $urandom};
      for (int i = 0; i < NUM_FWD; i++) begin
        f_valid[i] = 1'($urandom_range(0, 1));
        f_addr[i]  = 5'($urandom_range(0, 7));
        f_data[i]  = {$urandom, $urandom};
        f_pend[i]  = ($urandom_range(0, 3) == 0);
      end
      regs[$urandom_range(0, 7)] = {$urandom, $urandom};
      tick();
    end
    idle();
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
